// File: rtl/crc_cmd_master.sv
// Command-queue bus master for the CRC register port: queues read/write commands,
// issues each as a single Sel cycle and returns one response per command.
`timescale 1ns/1ps
module crc_cmd_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_rw,
   input  logic [31:0]                   cmd_addr,
   input  logic [31:0]                   cmd_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_rw,
   output logic [31:0]                   rsp_data,
   output logic [31:0]                   addr,
   output logic [31:0]                   data_wr,
   output logic                          RW,
   output logic                          Sel,
   input  logic [31:0]                   data_rd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [1:0]                    dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
   localparam logic [2:0]  LAT_C   = RD_LATENCY[2:0];

   // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
   // a producer holds its payload stable while valid is high and ready is low.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2, RESP = 2'd3} state_t;

   state_t         state, state_nxt;
   logic [64:0]    mem [FIFO_DEPTH];
   logic [64:0]    head;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count_nxt;
   logic [2:0]     rd_cnt;
   logic           push, pop;

   assign push = cmd_valid & cmd_ready;
   assign head = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (fifo_count != '0) state_nxt = ISSUE;
         ISSUE:   state_nxt = RW ? RESP : RDWAIT;
         RDWAIT:  if (rd_cnt == 3'd1) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop       = (state == IDLE) && (fifo_count != '0);
      rsp_valid = (state == RESP);
      busy      = (state != IDLE) || (fifo_count != '0);
      dbg_state = state;
   end

   always_comb begin
      count_nxt = fifo_count;
      if (push && !pop) count_nxt = fifo_count + 1'b1;
      if (pop && !push) count_nxt = fifo_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
   end

   // cmd_ready is registered from the next count so it stays low through reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         cmd_ready  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= count_nxt;
         cmd_ready  <= (count_nxt < DEPTH_C);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Sel     <= 1'b0;
         RW      <= 1'b0;
         addr    <= '0;
         data_wr <= '0;
      end else if (pop) begin
         Sel     <= 1'b1;
         RW      <= head[64];
         addr    <= head[63:32];
         data_wr <= head[64] ? head[31:0] : 32'h0;
      end else begin
         Sel     <= 1'b0;
         RW      <= 1'b0;
         addr    <= '0;
         data_wr <= '0;
      end
   end

   // rd_cnt counts down the remaining read-latency cycles; capture on the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt   <= '0;
         rsp_data <= '0;
         rsp_rw   <= 1'b0;
      end else begin
         unique case (state)
            ISSUE: begin
               if (RW) begin
                  rsp_data <= '0;
                  rsp_rw   <= 1'b1;
               end else begin
                  rd_cnt <= LAT_C;
               end
            end
            RDWAIT: begin
               rd_cnt <= rd_cnt - 1'b1;
               if (rd_cnt == 3'd1) begin
                  rsp_data <= data_rd;
                  rsp_rw   <= 1'b0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_data <= '0;
                  rsp_rw   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_cmd_master.sv
// Bench for crc_cmd_master: directed latency/stall/reset scenarios plus randomized
// traffic against a register-file model of the CRC block.
`timescale 1ns/1ps
module tb_crc_cmd_master;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_rw, rsp_valid, rsp_ready, rsp_rw, RW, Sel, busy;
   logic [31:0]   cmd_addr, cmd_wdata, rsp_data, addr, data_wr, data_rd;
   logic [CW-1:0] fifo_count;
   logic [1:0]    dbg_state;

   logic          cmd_valid_3, cmd_ready_3, cmd_rw_3, rsp_valid_3, rsp_ready_3, rsp_rw_3, RW_3, Sel_3, busy_3;
   logic [31:0]   cmd_addr_3, cmd_wdata_3, rsp_data_3, addr_3, data_wr_3, data_rd_3;
   logic [CW-1:0] fifo_count_3;
   logic [1:0]    dbg_state_3;

   crc_cmd_master #(.FIFO_DEPTH(DEPTH), .RD_LATENCY(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rw(rsp_rw), .rsp_data(rsp_data), .addr(addr), .data_wr(data_wr), .RW(RW), .Sel(Sel),
      .data_rd(data_rd), .busy(busy), .fifo_count(fifo_count), .dbg_state(dbg_state));

   crc_cmd_master #(.FIFO_DEPTH(DEPTH), .RD_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3), .cmd_rw(cmd_rw_3),
      .cmd_addr(cmd_addr_3), .cmd_wdata(cmd_wdata_3), .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
      .rsp_rw(rsp_rw_3), .rsp_data(rsp_data_3), .addr(addr_3), .data_wr(data_wr_3), .RW(RW_3), .Sel(Sel_3),
      .data_rd(data_rd_3), .busy(busy_3), .fifo_count(fifo_count_3), .dbg_state(dbg_state_3));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [32:0] exp_q[$];
   logic [31:0] dev_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference: commands complete in order; a read returns the latest completed write.
   function automatic logic [32:0] model_cmd(input logic rw, input logic [31:0] a, input logic [31:0] d);
      if (rw) begin
         ref_mem[a] = d;
         return {1'b1, 32'h0};
      end
      return {1'b0, ref_mem.exists(a) ? ref_mem[a] : init_val(a)};
   endfunction

   // CRC block models: read data valid exactly RD_LATENCY cycles after Sel, decoys otherwise.
   int pend_cnt = 0;
   logic [31:0] pend_val = '0;
   always @(negedge clk) begin
      if (pend_cnt > 0) begin
         pend_cnt = pend_cnt - 1;
         data_rd  = (pend_cnt == 0) ? pend_val : ~pend_val;
      end else begin
         data_rd = $urandom;
      end
      if (Sel && RW) dev_mem[addr] = data_wr;
      if (Sel && !RW) begin
         pend_cnt = 1;
         pend_val = dev_mem.exists(addr) ? dev_mem[addr] : init_val(addr);
      end
   end

   int pend_cnt3 = 0;
   logic [31:0] pend_val3 = '0;
   always @(negedge clk) begin
      if (pend_cnt3 > 0) begin
         pend_cnt3 = pend_cnt3 - 1;
         data_rd_3 = (pend_cnt3 == 0) ? pend_val3 : ~pend_val3;
      end else begin
         data_rd_3 = $urandom;
      end
      if (Sel_3 && !RW_3) begin
         pend_cnt3 = 3;
         pend_val3 = init_val(addr_3);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic rw, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         step();
         n++;
      end
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL push_wait: cmd_ready=%b expected 1 within 200 cycles", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
      step();
      cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, 7)) << 2;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if ({cmd_ready, rsp_valid, rsp_rw, rsp_data, addr, data_wr, RW, Sel, busy, fifo_count} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: ready=%b rv=%b sel=%b busy=%b cnt=%0d expected all 0",
                  cmd_ready, rsp_valid, Sel, busy, fifo_count);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_release_cycle: cmd_ready=%b expected 0", cmd_ready);
      end
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_release: cmd_ready=%b expected 1", cmd_ready);
      end
      step();
   endtask

   task automatic test_write();
      logic [32:0] e;
      e = model_cmd(1'b1, 32'h10, 32'hDEAD_BEEF);
      rsp_ready = 1'b1;
      push_cmd(1'b1, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      tests++;
      if (Sel !== 1'b0) begin
         fails++;
         $display("FAIL wr_sel_early: Sel=%b expected 0", Sel);
      end
      @(negedge clk);
      tests++;
      if ({Sel, RW, addr, data_wr} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL wr_bus: Sel=%b RW=%b addr=%h data=%h expected 1 1 00000010 deadbeef", Sel, RW, addr, data_wr);
      end
      @(negedge clk);
      tests++;
      if ({Sel, rsp_valid, rsp_rw, rsp_data} !== {1'b0, 1'b1, e}) begin
         fails++;
         $display("FAIL wr_rsp: Sel=%b rv=%b rw=%b data=%h expected 0 1 %b %h", Sel, rsp_valid, rsp_rw, rsp_data, e[32], e[31:0]);
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid, busy} !== 2'b00) begin
         fails++;
         $display("FAIL wr_done: rv=%b busy=%b expected 0 0", rsp_valid, busy);
      end
      step();
   endtask

   task automatic test_read();
      logic [32:0] e;
      dev_mem[32'h14] = 32'h1234_ABCD;
      ref_mem[32'h14] = 32'h1234_ABCD;
      e = model_cmd(1'b0, 32'h14, '0);
      rsp_ready = 1'b1;
      push_cmd(1'b0, 32'h14, $urandom);
      repeat (2) @(negedge clk);
      tests++;
      if ({Sel, RW, addr} !== {1'b1, 1'b0, 32'h14}) begin
         fails++;
         $display("FAIL rd_bus: Sel=%b RW=%b addr=%h expected 1 0 00000014", Sel, RW, addr);
      end
      @(negedge clk);
      tests++;
      if ({Sel, rsp_valid} !== 2'b00) begin
         fails++;
         $display("FAIL rd_wait: Sel=%b rv=%b expected 0 0", Sel, rsp_valid);
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_rw, rsp_data} !== {1'b1, e}) begin
         fails++;
         $display("FAIL rd_rsp: rv=%b rw=%b data=%h expected 1 0 %h", rsp_valid, rsp_rw, rsp_data, e[31:0]);
      end
      step();
   endtask

   task automatic test_full_stall();
      logic rw;
      logic [31:0] a, d;
      int sel_cnt = 0, got = 0, viol = 0, n = 0;
      logic [32:0] e;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rw = 1'($urandom_range(0, 1));
         a  = rand_addr();
         d  = $urandom;
         exp_q.push_back(model_cmd(rw, a, d));
         push_cmd(rw, a, d);
      end
      @(negedge clk);
      tests++;
      if ({cmd_ready, fifo_count} !== {1'b0, CW'(4)}) begin
         fails++;
         $display("FAIL full_ready: ready=%b cnt=%0d expected 0 4", cmd_ready, fifo_count);
      end
      repeat (8) begin
         @(negedge clk);
         if (Sel) sel_cnt++;
      end
      tests++;
      if (sel_cnt != 0 || rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL stall_no_sel: sel_cycles=%0d rv=%b expected 0 1", sel_cnt, rsp_valid);
      end
      step();
      rsp_ready = 1'b1;
      while (got < 5 && n < 80) begin
         @(negedge clk);
         n++;
         if (Sel && rsp_valid) viol++;
         if (rsp_valid && rsp_ready) begin
            e = exp_q.pop_front();
            got++;
            tests++;
            if ({rsp_rw, rsp_data} !== e) begin
               fails++;
               $display("FAIL stall_rsp%0d: rw=%b data=%h expected %b %h", got, rsp_rw, rsp_data, e[32], e[31:0]);
            end
         end
      end
      tests++;
      if (got != 5 || viol != 0) begin
         fails++;
         $display("FAIL stall_drain: responses=%0d overlaps=%0d expected 5 0", got, viol);
      end
      step();
      exp_q.delete();
   endtask

   task automatic test_rsp_hold();
      logic [32:0] e;
      logic [31:0] a;
      logic stable = 1'b1;
      int n = 0, hs = 0;
      a = rand_addr();
      e = model_cmd(1'b0, a, '0);
      rsp_ready = 1'b0;
      push_cmd(1'b0, a, '0);
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL hold_wait: rv=%b expected 1 within 20 cycles", rsp_valid);
      end
      for (int i = 0; i < 10; i++) begin
         if (!(rsp_valid === 1'b1 && {rsp_rw, rsp_data} === e)) stable = 1'b0;
         if (i < 9) @(negedge clk);
      end
      tests++;
      if (stable !== 1'b1) begin
         fails++;
         $display("FAIL hold_stable: last rv=%b data=%h expected 1 %h for 10 cycles", rsp_valid, rsp_data, e[31:0]);
      end
      step();
      rsp_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) hs++;
      end
      tests++;
      if (hs != 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL hold_handshake: handshakes=%0d busy=%b expected 1 0", hs, busy);
      end
      step();
   endtask

   task automatic test_reset_rdwait();
      logic [31:0] a;
      logic [32:0] e;
      int bad = 0, n = 0;
      a = rand_addr();
      rsp_ready = 1'b1;
      push_cmd(1'b0, rand_addr(), '0);
      push_cmd(1'b0, rand_addr(), '0);
      push_cmd(1'b1, a, 32'hBAD0_BAD0);
      #1 rst = 1'b1;
      #1;
      tests++;
      if ({cmd_ready, rsp_valid, rsp_rw, rsp_data, addr, data_wr, RW, Sel, busy, fifo_count} !== '0) begin
         fails++;
         $display("FAIL async_reset: ready=%b rv=%b sel=%b busy=%b cnt=%0d expected all 0",
                  cmd_ready, rsp_valid, Sel, busy, fifo_count);
      end
      step();
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid || Sel) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_discard: active_cycles=%0d expected 0", bad);
      end
      step();
      e = model_cmd(1'b0, a, '0);
      push_cmd(1'b0, a, '0);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if ({rsp_valid, rsp_rw, rsp_data} !== {1'b1, e}) begin
         fails++;
         $display("FAIL post_reset_rd: rv=%b data=%h expected 1 %h", rsp_valid, rsp_data, e[31:0]);
      end
      step();
   endtask

   task automatic test_random();
      localparam int N = 40;
      int got = 0, n = 0, viol = 0;
      logic [32:0] e;
      fork
         begin
            logic rw;
            logic [31:0] a, d;
            for (int i = 0; i < N; i++) begin
               repeat ($urandom_range(0, 2)) step();
               rw = 1'($urandom_range(0, 1));
               a  = rand_addr();
               d  = $urandom;
               exp_q.push_back(model_cmd(rw, a, d));
               push_cmd(rw, a, d);
            end
         end
         begin
            while (got < N && n < 2000) begin
               step();
               rsp_ready = 1'($urandom_range(0, 1));
               @(negedge clk);
               n++;
               if (Sel && rsp_valid) viol++;
               if (!Sel && {RW, addr, data_wr} != '0) viol++;
               if (rsp_valid && rsp_ready) begin
                  got++;
                  tests++;
                  if (exp_q.size() == 0) begin
                     fails++;
                     $display("FAIL rand_extra_rsp: rw=%b data=%h expected none", rsp_rw, rsp_data);
                  end else begin
                     e = exp_q.pop_front();
                     if ({rsp_rw, rsp_data} !== e) begin
                        fails++;
                        $display("FAIL rand_rsp%0d: rw=%b data=%h expected %b %h", got, rsp_rw, rsp_data, e[32], e[31:0]);
                     end
                  end
               end
            end
         end
      join
      tests++;
      if (got != N || viol != 0) begin
         fails++;
         $display("FAIL rand_summary: responses=%0d bus_violations=%0d expected %0d 0", got, viol, N);
      end
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_rd_latency3();
      logic [31:0] e;
      int n = 0, early = 0;
      e = init_val(32'h20);
      rsp_ready_3 = 1'b1;
      tests++;
      if (cmd_ready_3 !== 1'b1) begin
         fails++;
         $display("FAIL lat3_ready: cmd_ready=%b expected 1", cmd_ready_3);
      end
      cmd_valid_3 = 1'b1; cmd_rw_3 = 1'b0; cmd_addr_3 = 32'h20; cmd_wdata_3 = $urandom;
      step();
      cmd_valid_3 = 1'b0; cmd_addr_3 = '0; cmd_wdata_3 = '0;
      @(negedge clk);
      while (!Sel_3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if ({Sel_3, RW_3, addr_3} !== {1'b1, 1'b0, 32'h20}) begin
         fails++;
         $display("FAIL lat3_sel: Sel=%b RW=%b addr=%h expected 1 0 00000020", Sel_3, RW_3, addr_3);
      end
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid_3) early++;
      end
      tests++;
      if (early != 0) begin
         fails++;
         $display("FAIL lat3_early: early_valid_cycles=%0d expected 0", early);
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid_3, rsp_rw_3, rsp_data_3} !== {1'b1, 1'b0, e}) begin
         fails++;
         $display("FAIL lat3_rsp: rv=%b rw=%b data=%h expected 1 0 %h", rsp_valid_3, rsp_rw_3, rsp_data_3, e);
      end
      step();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0; data_rd = '0;
      cmd_valid_3 = 0; cmd_rw_3 = 0; cmd_addr_3 = '0; cmd_wdata_3 = '0; rsp_ready_3 = 0; data_rd_3 = '0;
      test_reset();
      test_write();
      test_read();
      test_full_stall();
      test_rsp_hold();
      test_reset_rdwait();
      test_random();
      test_rd_latency3();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
